weight_buffer_loader_b3: RTL and testbench



---
 rtl/weight_buffer_loader_b3_pkg.sv | 16 +
 rtl/weight_buffer_loader_b3_weight_packer.sv | 41 ++++
 rtl/weight_buffer_loader_b3.sv | 66 ++++++
 tb/tb_weight_buffer_loader_b3.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_loader_b3_pkg.sv
// weight_buffer_loader_b3_pkg: block-3 weight buffer geometry and loader state encoding
package weight_buffer_loader_b3_pkg;
    localparam int W_WIDTH    = 7;
    localparam int PACK       = 4;
    localparam int DEPTH      = 128;
    localparam int ADDR_WIDTH = 7;
    localparam int WORD_WIDTH = W_WIDTH * PACK;
    localparam int LANE_WIDTH = $clog2(PACK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/weight_buffer_loader_b3_weight_packer.sv
// weight_packer: shifts weights into a word, first weight ending up in the top lane
module weight_packer
    import weight_buffer_loader_b3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [W_WIDTH-1:0]    data,
    output logic                  lane_last,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word
);
    logic [LANE_WIDTH-1:0] lane;
    logic [WORD_WIDTH-1:0] pack;
    logic [WORD_WIDTH-1:0] next_pack;

    assign next_pack = {pack[WORD_WIDTH-W_WIDTH-1:0], data};
    assign lane_last = lane == LANE_WIDTH'(PACK - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            pack       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else if (clear) begin
            lane       <= '0;
            pack       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= accept && lane_last;
            if (accept) begin
                pack <= next_pack;
                lane <= lane_last ? '0 : lane + 1'b1;
                if (lane_last)
                    word <= next_pack;
            end
        end
    end
endmodule

// File: rtl/weight_buffer_loader_b3.sv
// weight_buffer_loader_b3: packs streamed weights into 128 RAM words and flags completion
module weight_buffer_loader_b3
    import weight_buffer_loader_b3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  w_in_valid,
    input  logic [W_WIDTH-1:0]    w_in_data,
    output logic                  w_in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  load_done
);
    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   words_taken;
    logic                  accept, clear, lane_last, last_word;

    assign w_in_ready = state == LOAD;
    assign busy       = state == LOAD || state == FLUSH;
    assign load_done  = state == DONE;
    assign ram_addr   = addr;
    assign accept     = w_in_valid && w_in_ready && !abort;
    assign clear      = start && !abort && (state == IDLE || state == DONE);
    // a word may still be in flight to the RAM, so count it as taken
    assign words_taken = {1'b0, addr} + {{ADDR_WIDTH{1'b0}}, ram_we};
    assign last_word   = accept && lane_last && words_taken == (ADDR_WIDTH+1)'(DEPTH - 1);

    weight_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .accept     (accept),
        .data       (w_in_data),
        .lane_last  (lane_last),
        .word_valid (ram_we),
        .word       (ram_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_next;
            if (clear)
                addr <= '0;
            else if (ram_we)
                addr <= addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = clear ? LOAD : state;
            LOAD:       state_next = abort ? IDLE : last_word ? FLUSH : LOAD;
            FLUSH:      state_next = abort ? IDLE : DONE;
            default:    state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_weight_buffer_loader_b3.sv
// tb_weight_buffer_loader_b3: directed checks of packing, addressing, abort, restart and reset
module tb_weight_buffer_loader_b3;
    logic        clk, rst_n, start, abort, w_in_valid;
    logic [6:0]  w_in_data;
    logic        w_in_ready, ram_we, busy, load_done;
    logic [6:0]  ram_addr;
    logic [27:0] ram_wdata;

    int checks = 0;
    int errors = 0;
    logic [6:0]  wa[$];
    logic [27:0] wd[$];

    weight_buffer_loader_b3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .w_in_valid (w_in_valid),
        .w_in_data  (w_in_data),
        .w_in_ready (w_in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .load_done  (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
            checks++;
            assert (busy === 1'b1) else begin
                errors++;
                $error("FAIL we_outside_busy: observed busy=%b expected=1", busy);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] exp_word(input int i);
        logic [27:0] w = '0;
        for (int j = 0; j < 4; j++)
            w[27-7*j -: 7] = 7'((4*i + j) % 128);
        return w;
    endfunction

    task automatic send(input logic [6:0] d, input int bub);
        int n = 0;
        while (32'($urandom_range(0, 99)) < bub) begin
            w_in_valid = 1'b0;
            step();
        end
        w_in_valid = 1'b1;
        w_in_data  = d;
        while (!w_in_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_in_load", 32'(w_in_ready), 32'd1);
        step();
        w_in_valid = 1'b0;
    endtask

    task automatic check_writes(input int n);
        chk("wr_count", 32'(wa.size()), 32'(n));
        for (int i = 0; i < wa.size() && i < n; i++) begin
            chk("wr_addr", 32'(wa[i]), 32'(i));
            chk("wr_data", 32'(wd[i]), 32'(exp_word(i)));
        end
    endtask

    task automatic full_load(input int bub, input int start_at);
        wa.delete();
        wd.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 512; k++) begin
            if (k == start_at) start = 1'b1;
            send(7'(k % 128), bub);
            start = 1'b0;
        end
        chk("flush_we", 32'(ram_we), 32'd1);
        chk("flush_addr", 32'(ram_addr), 32'd127);
        chk("flush_done", 32'(load_done), 32'd0);
        chk("flush_ready", 32'(w_in_ready), 32'd0);
        step();
        chk("done_flag", 32'(load_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_we", 32'(ram_we), 32'd0);
        check_writes(128);
        chk("first_word", 32'(wd.size() > 0 ? wd[0] : 28'h0), 32'h0004103);
        chk("last_word", 32'(wd.size() > 127 ? wd[127] : 28'h0), 32'hF9F7F7F);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_in_valid = 1'b0; w_in_data = '0;
        step();
        step();
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_ready", 32'(w_in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        rst_n = 1'b1;
        step();

        full_load(0, -1);

        wa.delete();
        w_in_valid = 1'b1;
        w_in_data  = 7'h55;
        for (int i = 0; i < 4; i++) begin
            chk("done_hold_ready", 32'(w_in_ready), 32'd0);
            chk("done_hold_flag", 32'(load_done), 32'd1);
            step();
        end
        w_in_valid = 1'b0;
        chk("done_no_write", 32'(wa.size()), 32'd0);

        full_load(30, -1);

        wa.delete();
        wd.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) send(7'(k), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(load_done), 32'd0);
        chk("abort_ready", 32'(w_in_ready), 32'd0);
        step();
        step();
        check_writes(1);
        full_load(0, -1);

        full_load(0, 200);

        wa.delete();
        wd.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 300; k++) send(7'(k % 128), 0);
        chk("pre_rst_we", 32'(ram_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_ready", 32'(w_in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd0);
        chk("arst_wdata", 32'(ram_wdata), 32'd0);
        #2 rst_n = 1'b1;
        step();
        wa.delete();
        w_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("idle_hold_ready", 32'(w_in_ready), 32'd0);
            chk("idle_hold_busy", 32'(busy), 32'd0);
            step();
        end
        w_in_valid = 1'b0;
        chk("idle_no_write", 32'(wa.size()), 32'd0);
        full_load(0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
